// File: rtl/free_list_pkg.sv
// Shared types and constants for the physical-register free list.
package free_list_pkg;

    localparam int NUM_PHYS       = 64;
    localparam int NUM_ARCH       = 32;
    localparam int PHYS_ADDRWIDTH = 6;
    localparam int COUNT_W        = 7;
    localparam int RAT_W          = NUM_ARCH * PHYS_ADDRWIDTH;

    typedef logic [PHYS_ADDRWIDTH-1:0] phys_id_t;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        CAPTURE = 2'd1,
        SCAN    = 2'd2
    } fl_state_e;

    // Arch register 0 lives in the MSBs of the packed retirement RAT.
    function automatic phys_id_t ret_rat_entry(input logic [RAT_W-1:0] rat,
                                               input int unsigned idx);
        return rat[(NUM_ARCH-1-idx)*PHYS_ADDRWIDTH +: PHYS_ADDRWIDTH];
    endfunction

endpackage

// File: rtl/free_list_if.sv
// Rename/commit side of the free list; clock, reset and freeze stay plain ports.
// Handshake: an ID is taken when allocReq_IN && allocValid_OUT at a rising edge; freeReq_IN has no back-pressure.
interface free_list_if;
    import free_list_pkg::*;

    logic                allocReq_IN;
    phys_id_t            allocId_OUT;
    logic                allocValid_OUT;
    logic                freeReq_IN;
    phys_id_t            freeId_IN;
    logic                flush_IN;
    logic [RAT_W-1:0]    retRat_IN;
    logic [NUM_ARCH-1:0] retRatValid_IN;
    logic                busy_OUT;
    logic [COUNT_W-1:0]  count_OUT;
    logic                overflow_OUT;
    fl_state_e           state_dbg;

    modport slave (
        input  allocReq_IN, freeReq_IN, freeId_IN, flush_IN, retRat_IN, retRatValid_IN,
        output allocId_OUT, allocValid_OUT, busy_OUT, count_OUT, overflow_OUT, state_dbg
    );

    modport master (
        output allocReq_IN, freeReq_IN, freeId_IN, flush_IN, retRat_IN, retRatValid_IN,
        input  allocId_OUT, allocValid_OUT, busy_OUT, count_OUT, overflow_OUT, state_dbg
    );

endinterface

// File: rtl/free_list_fifo.sv
// 64-entry show-ahead circular buffer of physical register IDs.
module free_list_fifo
    import free_list_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  phys_id_t           push_data,
    output phys_id_t           head_data,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty
);

    phys_id_t mem [NUM_PHYS];
    phys_id_t head;
    phys_id_t tail;
    logic     do_push;
    logic     do_pop;

    assign full      = (count == COUNT_W'(NUM_PHYS));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < NUM_PHYS; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            if (clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_push) begin
                    mem[tail] <= push_data;
                    tail      <= tail + 1'b1;
                end
                if (do_pop) begin
                    head <= head + 1'b1;
                end
                // Simultaneous push and pop leave the count unchanged.
                if (do_push && !do_pop) begin
                    count <= count + 1'b1;
                end else if (do_pop && !do_push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/free_list.sv
// Free list top: FSM, retirement-RAT mask capture and rebuild scan around the FIFO.
module free_list
    import free_list_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FREEZE,
    free_list_if.slave  bus
);

    fl_state_e           state;
    fl_state_e           state_next;
    phys_id_t            scan_idx;
    logic [NUM_PHYS-1:0] in_use_mask;
    logic [NUM_PHYS-1:0] mask_next;
    logic                overflow;

    logic                normal_live;
    logic                fifo_clear;
    logic                fifo_push;
    logic                fifo_pop;
    phys_id_t            fifo_push_data;
    phys_id_t            fifo_head;
    logic [COUNT_W-1:0]  fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                overflow_set;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= SCAN;
        end else if (!FREEZE) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            NORMAL:  if (bus.flush_IN) state_next = CAPTURE;
            CAPTURE: state_next = bus.flush_IN ? CAPTURE : SCAN;
            SCAN: begin
                if (bus.flush_IN) begin
                    state_next = CAPTURE;
                end else if (scan_idx == phys_id_t'(NUM_PHYS-1)) begin
                    state_next = NORMAL;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    // A flush cycle discards rename/commit traffic; the rebuild recovers any freed ID.
    always_comb begin
        normal_live    = (state == NORMAL) && !bus.flush_IN;
        fifo_clear     = (state == CAPTURE);
        fifo_pop       = normal_live && bus.allocReq_IN && !fifo_empty;
        fifo_push      = (normal_live && bus.freeReq_IN && !fifo_full) ||
                         ((state == SCAN) && !bus.flush_IN && !in_use_mask[scan_idx]);
        fifo_push_data = (state == SCAN) ? scan_idx : bus.freeId_IN;
        overflow_set   = normal_live && bus.freeReq_IN && fifo_full;
    end

    always_comb begin
        mask_next = '0;
        for (int unsigned i = 0; i < NUM_ARCH; i++) begin
            if (bus.retRatValid_IN[i]) begin
                mask_next[ret_rat_entry(bus.retRat_IN, i)] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            scan_idx    <= '0;
            in_use_mask <= '0;
            overflow    <= 1'b0;
        end else if (!FREEZE) begin
            if (state == CAPTURE) begin
                in_use_mask <= mask_next;
                scan_idx    <= '0;
            end else if (state == SCAN) begin
                scan_idx <= scan_idx + 1'b1;
            end
            if (overflow_set) begin
                overflow <= 1'b1;
            end
        end
    end

    free_list_fifo u_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .en        (!FREEZE),
        .clear     (fifo_clear),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data (fifo_push_data),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        bus.allocId_OUT    = fifo_head;
        bus.allocValid_OUT = (state == NORMAL) && !fifo_empty;
        bus.busy_OUT       = (state != NORMAL);
        bus.count_OUT      = fifo_count;
        bus.overflow_OUT   = overflow;
        bus.state_dbg      = state;
    end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset fill, alloc/free, overflow, flush rebuild, freeze and restart.
module tb_free_list;
    import free_list_pkg::*;

    logic clk;
    logic rst;
    logic freeze;
    int   compared;
    int   mismatched;
    int   n;
    logic [RAT_W-1:0] rat;

    free_list_if fl_if ();

    free_list dut (
        .CLK    (clk),
        .RESET  (rst),
        .FREEZE (freeze),
        .bus    (fl_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse flush for one cycle and count the samples in which busy stays high.
    task automatic flush_and_measure(input int freeze_from, input int freeze_to, output int busy_n);
        busy_n = 0;
        fl_if.flush_IN = 1'b1;
        tick();
        fl_if.flush_IN = 1'b0;
        while (fl_if.busy_OUT && busy_n < 300) begin
            busy_n++;
            freeze = (busy_n >= freeze_from) && (busy_n < freeze_to);
            tick();
        end
        freeze = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        freeze     = 1'b0;
        fl_if.allocReq_IN    = 1'b0;
        fl_if.freeReq_IN     = 1'b0;
        fl_if.freeId_IN      = '0;
        fl_if.flush_IN       = 1'b0;
        fl_if.retRat_IN      = '0;
        fl_if.retRatValid_IN = '0;

        // Reset state
        tick();
        tick();
        chk("rst_busy", 64'(fl_if.busy_OUT), 64'd1);
        chk("rst_valid", 64'(fl_if.allocValid_OUT), 64'd0);
        chk("rst_count", 64'(fl_if.count_OUT), 64'd0);
        chk("rst_id", 64'(fl_if.allocId_OUT), 64'd0);
        chk("rst_ovf", 64'(fl_if.overflow_OUT), 64'd0);
        chk("rst_state", 64'(fl_if.state_dbg), 64'(SCAN));

        // Reset fill scan
        rst = 1'b0;
        n = 0;
        while (fl_if.busy_OUT && n < 300) begin
            n++;
            tick();
        end
        chk("reset_latency", 64'(n), 64'd64);
        chk("fill_count", 64'(fl_if.count_OUT), 64'd64);
        chk("fill_valid", 64'(fl_if.allocValid_OUT), 64'd1);
        chk("fill_state", 64'(fl_if.state_dbg), 64'(NORMAL));

        // Drain all 64 IDs in ascending order
        fl_if.allocReq_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("alloc_first3", 64'(fl_if.allocId_OUT), 64'(i));
            tick();
        end
        chk("count_61", 64'(fl_if.count_OUT), 64'd61);
        for (int i = 3; i < 64; i++) begin
            chk("alloc_rest", 64'(fl_if.allocId_OUT), 64'(i));
            tick();
        end
        chk("empty_count", 64'(fl_if.count_OUT), 64'd0);
        chk("empty_valid", 64'(fl_if.allocValid_OUT), 64'd0);
        tick();
        chk("empty_req_count", 64'(fl_if.count_OUT), 64'd0);
        chk("empty_req_valid", 64'(fl_if.allocValid_OUT), 64'd0);
        chk("empty_req_id", 64'(fl_if.allocId_OUT), 64'd0);
        fl_if.allocReq_IN = 1'b0;

        // Free ID 5 into the empty list
        fl_if.freeReq_IN = 1'b1;
        fl_if.freeId_IN  = 6'd5;
        tick();
        fl_if.freeReq_IN = 1'b0;
        chk("free5_valid", 64'(fl_if.allocValid_OUT), 64'd1);
        chk("free5_id", 64'(fl_if.allocId_OUT), 64'd5);
        chk("free5_count", 64'(fl_if.count_OUT), 64'd1);

        // Queue 5,21..29 then simultaneous pop/push of 40
        fl_if.freeReq_IN = 1'b1;
        for (int i = 21; i <= 29; i++) begin
            fl_if.freeId_IN = 6'(i);
            tick();
        end
        chk("count_10", 64'(fl_if.count_OUT), 64'd10);
        fl_if.allocReq_IN = 1'b1;
        fl_if.freeId_IN   = 6'd40;
        tick();
        fl_if.freeReq_IN  = 1'b0;
        chk("simul_count", 64'(fl_if.count_OUT), 64'd10);
        for (int i = 0; i < 10; i++) begin
            chk("simul_order", 64'(fl_if.allocId_OUT), (i < 9) ? 64'(21 + i) : 64'd40);
            tick();
        end
        fl_if.allocReq_IN = 1'b0;
        chk("simul_drained", 64'(fl_if.count_OUT), 64'd0);

        // Fill to 64, then overflow
        fl_if.freeReq_IN = 1'b1;
        for (int i = 0; i < 64; i++) begin
            fl_if.freeId_IN = 6'(i);
            tick();
        end
        fl_if.freeReq_IN = 1'b0;
        chk("full_count", 64'(fl_if.count_OUT), 64'd64);
        chk("full_no_ovf", 64'(fl_if.overflow_OUT), 64'd0);
        fl_if.freeReq_IN = 1'b1;
        fl_if.freeId_IN  = 6'd7;
        tick();
        fl_if.freeReq_IN = 1'b0;
        chk("ovf_set", 64'(fl_if.overflow_OUT), 64'd1);
        chk("ovf_count", 64'(fl_if.count_OUT), 64'd64);
        tick();
        tick();
        chk("ovf_sticky", 64'(fl_if.overflow_OUT), 64'd1);

        // Flush rebuild: arch i -> phys i+32, all valid
        for (int i = 0; i < NUM_ARCH; i++) begin
            rat[(NUM_ARCH-1-i)*PHYS_ADDRWIDTH +: PHYS_ADDRWIDTH] = 6'(i + 32);
        end
        fl_if.retRat_IN      = rat;
        fl_if.retRatValid_IN = '1;
        flush_and_measure(1000, 1000, n);
        chk("flush_latency", 64'(n), 64'd65);
        chk("flush_count", 64'(fl_if.count_OUT), 64'd32);
        chk("flush_ovf_kept", 64'(fl_if.overflow_OUT), 64'd1);
        fl_if.allocReq_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("flush_alloc", 64'(fl_if.allocId_OUT), 64'(i));
            tick();
        end
        fl_if.allocReq_IN = 1'b0;
        chk("flush_alloc_count", 64'(fl_if.count_OUT), 64'd29);

        // Freeze 5 cycles mid-scan
        flush_and_measure(10, 15, n);
        chk("freeze_latency", 64'(n), 64'd70);
        chk("freeze_count", 64'(fl_if.count_OUT), 64'd32);

        // Flush mid-scan restarts the rebuild
        fl_if.flush_IN = 1'b1;
        tick();
        fl_if.flush_IN = 1'b0;
        repeat (20) tick();
        chk("restart_busy", 64'(fl_if.busy_OUT), 64'd1);
        chk("restart_state", 64'(fl_if.state_dbg), 64'(SCAN));
        flush_and_measure(1000, 1000, n);
        chk("restart_latency", 64'(n), 64'd65);
        chk("restart_count", 64'(fl_if.count_OUT), 64'd32);

        // Frozen cycle drops an alloc request
        freeze = 1'b1;
        fl_if.allocReq_IN = 1'b1;
        tick();
        freeze = 1'b0;
        fl_if.allocReq_IN = 1'b0;
        chk("freeze_drop_count", 64'(fl_if.count_OUT), 64'd32);
        chk("freeze_drop_id", 64'(fl_if.allocId_OUT), 64'd0);

        // Reset overrides freeze and clears overflow
        freeze = 1'b1;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        freeze = 1'b0;
        chk("rerst_ovf", 64'(fl_if.overflow_OUT), 64'd0);
        chk("rerst_count", 64'(fl_if.count_OUT), 64'd0);
        chk("rerst_busy", 64'(fl_if.busy_OUT), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
